// File: rtl/feat_bank_sched.sv
// rtl/feat_bank_sched.sv - ping-pong bank sequencer and single-port arbiter for the feature buffer
// Optional write address guard: define FEAT_SCHED_ADDR_GUARD_EN.
module feat_bank_sched #(
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = 128,
    parameter int              RD_LAT   = 1,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 16'hFFFF
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              layer_start,
    input  logic              layer_done,
    input  logic              ld_req,
    output logic              ld_grant,
    input  logic              ld_wr_en,
    input  logic [ADDR_W-1:0] ld_wr_addr,
    input  logic [DATA_W-1:0] ld_wr_data,
    input  logic              ld_done,
    input  logic              ex_wr_en,
    input  logic [ADDR_W-1:0] ex_wr_addr,
    input  logic [DATA_W-1:0] ex_wr_data,
    input  logic              ex_rd_en,
    input  logic [ADDR_W-1:0] ex_rd_addr,
    output logic              ex_rd_valid,
    input  logic              rb_rd_en,
    input  logic [ADDR_W-1:0] rb_rd_addr,
    output logic              rb_rd_valid,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [DATA_W-1:0] buf_wr_data,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic              buf_rd_valid,
    output logic              bank_rd_sel,
    output logic              bank_wr_sel,
    output logic              sched_idle,
    output logic [5:0]        layer_cnt,
    output logic [16:0]       wr_word_cnt
`ifdef FEAT_SCHED_ADDR_GUARD_EN
    ,
    output logic              addr_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_SWAP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              bank_rd_sel_q, bank_rd_sel_d;
    logic              bank_wr_sel_q, bank_wr_sel_d;
    logic              ld_grant_q, ld_grant_d;
    logic              sched_idle_q, sched_idle_d;
    logic [5:0]        layer_cnt_q, layer_cnt_d;
    logic [16:0]       wr_word_cnt_q, wr_word_cnt_d;
    logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
    logic [RD_LAT-1:0] rd_tag_q, rd_tag_d;
    logic              addr_err_q, addr_err_d;

    logic              wr_own;
    logic              wr_ok;
    logic [ADDR_W-1:0] wr_addr_sel;
    logic              rd_from_ex;
    logic              rd_from_rb;

    always_comb begin
        state_d       = state_q;
        bank_rd_sel_d = bank_rd_sel_q;
        layer_cnt_d   = layer_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (layer_start)  state_d = S_RUN;
                else if (ld_req)  state_d = S_LOAD;
            end
            S_LOAD: if (ld_done)    state_d = S_IDLE;
            S_RUN:  if (layer_done) state_d = S_SWAP;
            S_SWAP: begin
                state_d       = S_IDLE;
                bank_rd_sel_d = ~bank_rd_sel_q;
                layer_cnt_d   = layer_cnt_q + 6'd1;
            end
            default: state_d = S_IDLE;
        endcase

        ld_grant_d    = (state_d == S_LOAD);
        sched_idle_d  = (state_d == S_IDLE);
        bank_wr_sel_d = (state_d == S_RUN) ? ~bank_rd_sel_d : bank_rd_sel_d;
    end

    // Ownership-gated, zero-latency write/read routing to the buffer
    always_comb begin
        wr_own      = ((state_q == S_LOAD) && ld_wr_en) || ((state_q == S_RUN) && ex_wr_en);
        wr_addr_sel = (state_q == S_LOAD) ? ld_wr_addr : ex_wr_addr;
`ifdef FEAT_SCHED_ADDR_GUARD_EN
        wr_ok       = wr_own && (wr_addr_sel <= MAX_ADDR);
        addr_err_d  = addr_err_q || (wr_own && !wr_ok);
`else
        wr_ok       = wr_own;
        addr_err_d  = 1'b0;
`endif
        buf_wr_en   = wr_ok;
        buf_wr_addr = wr_addr_sel;
        buf_wr_data = (state_q == S_LOAD) ? ld_wr_data : ex_wr_data;

        rd_from_ex  = (state_q == S_RUN)  && ex_rd_en;
        rd_from_rb  = (state_q == S_IDLE) && rb_rd_en;
        buf_rd_en   = rd_from_ex || rd_from_rb;
        buf_rd_addr = (state_q == S_RUN) ? ex_rd_addr : rb_rd_addr;
    end

    always_comb begin
        wr_word_cnt_d = wr_word_cnt_q;
        if ((state_d != state_q) && ((state_d == S_LOAD) || (state_d == S_RUN)))
            wr_word_cnt_d = 17'd0;
        else if (wr_ok && (wr_word_cnt_q != 17'h1FFFF))
            wr_word_cnt_d = wr_word_cnt_q + 17'd1;
    end

    // Tag 1 = layer_exec, 0 = host; valid steered by the tag leaving the pipe
    always_comb begin
        rd_vld_d    = rd_vld_q;
        rd_tag_d    = rd_tag_q;
        rd_vld_d[0] = buf_rd_en;
        rd_tag_d[0] = rd_from_ex;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
            rd_tag_d[i] = rd_tag_q[i-1];
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q       <= S_IDLE;
            bank_rd_sel_q <= 1'b0;
            bank_wr_sel_q <= 1'b0;
            ld_grant_q    <= 1'b0;
            sched_idle_q  <= 1'b1;
            layer_cnt_q   <= 6'd0;
            wr_word_cnt_q <= 17'd0;
            rd_vld_q      <= '0;
            rd_tag_q      <= '0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bank_rd_sel_q <= bank_rd_sel_d;
            bank_wr_sel_q <= bank_wr_sel_d;
            ld_grant_q    <= ld_grant_d;
            sched_idle_q  <= sched_idle_d;
            layer_cnt_q   <= layer_cnt_d;
            wr_word_cnt_q <= wr_word_cnt_d;
            rd_vld_q      <= rd_vld_d;
            rd_tag_q      <= rd_tag_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign ex_rd_valid = buf_rd_valid && rd_vld_q[RD_LAT-1] &&  rd_tag_q[RD_LAT-1];
    assign rb_rd_valid = buf_rd_valid && rd_vld_q[RD_LAT-1] && !rd_tag_q[RD_LAT-1];
    assign ld_grant    = ld_grant_q;
    assign sched_idle  = sched_idle_q;
    assign bank_rd_sel = bank_rd_sel_q;
    assign bank_wr_sel = bank_wr_sel_q;
    assign layer_cnt   = layer_cnt_q;
    assign wr_word_cnt = wr_word_cnt_q;

`ifdef FEAT_SCHED_ADDR_GUARD_EN
    assign addr_err = addr_err_q;
`else
    logic unused_guard;
    assign unused_guard = ^{MAX_ADDR, addr_err_q, addr_err_d};
`endif

endmodule
